// File: rtl/alu_result_uart_tx_pkg.sv
// Shared types and constants for the ALU result serial transmitter.
package alu_result_uart_tx_pkg;

  // Transmit FSM states
  //   ST_IDLE   | line high, waiting for a buffered result
  //   ST_START  | start bit (line low)
  //   ST_DATA   | data bits, LSB first
  //   ST_PARITY | optional parity bit
  //   ST_STOP   | stop bit (line high), may chain straight into the next frame
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/alu_result_uart_tx_if.sv
// ALU result bus plus the serial-side status outputs of the transmitter.
interface alu_result_uart_tx_if #(
  parameter int WIDTH = 16
);
  logic [2*WIDTH:0] ALU_Out;
  logic             ALU_Flag;
  logic             TX_OUT;
  logic             Busy;
  logic             Fifo_Empty;
  logic             Overflow;

  modport master (
    output ALU_Out, ALU_Flag,
    input  TX_OUT, Busy, Fifo_Empty, Overflow
  );

  modport slave (
    input  ALU_Out, ALU_Flag,
    output TX_OUT, Busy, Fifo_Empty, Overflow
  );
endinterface

// File: rtl/alu_result_fifo.sv
// Synchronous DW x DEPTH FIFO with combinational head read.
// A push on a full FIFO is honoured only together with a pop; the head is
// read before the edge, so the write may reuse the slot being vacated.
module alu_result_fifo #(
  parameter int DW    = 33,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer, occupancy and storage update
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_result_uart_tx.sv
// Captures valid ALU results into a FIFO and ships each one as a serial
// frame: start, DW data bits LSB first, optional parity, stop.
module alu_result_uart_tx
  import alu_result_uart_tx_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 8,
  parameter int PAR_EN       = 1,
  parameter int PAR_ODD      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_result_uart_tx_if.slave   bus
);
  localparam int DW   = 2 * WIDTH + 1;
  localparam int BW   = $clog2(CLKS_PER_BIT);
  localparam int BITW = $clog2(DW);
  localparam logic PAR_INV = (PAR_ODD != 0);

  tx_state_e       state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [BITW-1:0] bit_q, bit_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DW-1:0]   fifo_rd_data;
  logic            baud_last;

  alu_result_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (bus.ALU_Out),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

  // Capture: a full FIFO still accepts a word when the FSM pops on the same edge
  assign fifo_push = bus.ALU_Flag && (!fifo_full || fifo_pop);
  assign ovf_d     = ovf_q || (bus.ALU_Flag && fifo_full && !fifo_pop);

  // Next-state, counters, shift register and registered line level
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    fifo_pop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rd_data;
          par_d    = (^fifo_rd_data) ^ PAR_INV;
          baud_d   = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == BITW'(DW - 1)) begin
            state_d = (PAR_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d   = bit_q + BITW'(1);
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rd_data;
            par_d    = (^fifo_rd_data) ^ PAR_INV;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    // Line level follows the state being entered so TX_OUT stays registered
    case (state_d)
      ST_START:  tx_d = LINE_START;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = LINE_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Transmitter state registers; reset aborts any frame in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= LINE_IDLE;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.TX_OUT     = tx_q;
  assign bus.Busy       = busy_q;
  assign bus.Fifo_Empty = fifo_empty;
  assign bus.Overflow   = ovf_q;

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Directed and randomized checks of alu_result_uart_tx against a frame-level
// reference: expected line levels are derived from the word alone.
module tb_alu_result_uart_tx;
  localparam int WIDTH   = 16;
  localparam int DEPTH   = 4;
  localparam int CPB     = 4;
  localparam int PAR_EN  = 1;
  localparam int PAR_ODD = 0;
  localparam int DW      = 2 * WIDTH + 1;
  localparam int FRAME   = (DW + 2 + PAR_EN) * CPB;
  localparam int LOGN    = 20000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_result_uart_tx_if #(.WIDTH(WIDTH)) bus ();

  alu_result_uart_tx #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .CLKS_PER_BIT (CPB),
    .PAR_EN       (PAR_EN),
    .PAR_ODD      (PAR_ODD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int rd_idx   = 0;

  logic line_log [LOGN];
  logic busy_log [LOGN];
  int   cyc = 0;

  // Line recorder: one sample per cycle, taken on the falling edge
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      line_log[cyc] <= bus.TX_OUT;
      busy_log[cyc] <= bus.Busy;
    end
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_words(input logic [DW-1:0] ws[$]);
    foreach (ws[i]) begin
      bus.ALU_Out  = ws[i];
      bus.ALU_Flag = 1'b1;
      tick();
    end
    bus.ALU_Flag = 1'b0;
  endtask

  function automatic logic ref_parity(input logic [DW-1:0] w);
    int ones = 0;
    for (int i = 0; i < DW; i++) ones += int'(w[i]);
    return logic'((ones % 2) != 0) ^ logic'(PAR_ODD != 0);
  endfunction

  // Expected line level at cycle c of a frame carrying w
  function automatic logic ref_level(input logic [DW-1:0] w, input int c);
    int b = c / CPB;
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
    if (PAR_EN != 0 && b == DW + 1) return ref_parity(w);
    return 1'b1;
  endfunction

  // Decode the next frame from the recorded line, starting at rd_idx
  task automatic rx_frame(input logic [DW-1:0] w, input bit b2b, input string tag);
    int waited = 0;
    int shape_err = 0;
    int busy_err = 0;
    logic [DW-1:0] got = '0;
    logic par_got = 1'b0;
    while (rd_idx < cyc && line_log[rd_idx] === 1'b1 && waited < 8 * FRAME) begin
      rd_idx++;
      waited++;
    end
    check({tag, "_frame_seen"}, 64'(rd_idx + FRAME <= cyc), 64'(1));
    if (rd_idx + FRAME > cyc) return;
    for (int c = 0; c < FRAME; c++) begin
      logic lvl;
      int b;
      lvl = line_log[rd_idx + c];
      b = c / CPB;
      if (lvl !== ref_level(w, c)) shape_err++;
      if (busy_log[rd_idx + c] !== 1'b1) busy_err++;
      if (c % CPB == CPB / 2) begin
        if (b >= 1 && b <= DW) got[b-1] = lvl;
        if (b == DW + 1) par_got = lvl;
      end
    end
    check({tag, "_data"}, 64'(got), 64'(w));
    check({tag, "_parity"}, 64'(par_got), 64'(ref_parity(w)));
    check({tag, "_shape_errs"}, 64'(shape_err), 64'(0));
    check({tag, "_busy_errs"}, 64'(busy_err), 64'(0));
    if (b2b) check({tag, "_gap"}, 64'(waited), 64'(0));
    rd_idx += FRAME;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"}, 64'(bus.TX_OUT), 64'(1));
    check({tag, "_busy"}, 64'(bus.Busy), 64'(0));
    check({tag, "_empty"}, 64'(bus.Fifo_Empty), 64'(1));
  endtask

  logic [DW-1:0] q[$];
  logic [DW-1:0] acc[$];
  logic          model_ovf;
  int            k;
  int            line_err;

  initial begin
    rst          = 1'b0;
    bus.ALU_Flag = 1'b1;
    bus.ALU_Out  = 33'h1_2345_6789;
    model_ovf    = 1'b0;

    // 1: reset hold (flag ignored), then quiet idle
    wait_ticks(4);
    check_idle("rst_hold");
    check("rst_hold_ovf", 64'(bus.Overflow), 64'(0));
    bus.ALU_Flag = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_idle("idle");
      check("idle_ovf", 64'(bus.Overflow), 64'(0));
    end

    // 2: single word
    rd_idx = cyc;
    q.delete(); q.push_back(33'h0_0000_0001);
    push_words(q);
    wait_ticks(FRAME + 10);
    rx_frame(33'h0_0000_0001, 1'b0, "single");
    check("single_busy_after", 64'(busy_log[rd_idx]), 64'(0));
    check_idle("single_end");

    // 3: -1 then 3, back to back
    rd_idx = cyc;
    q.delete(); q.push_back(33'h1_FFFF_FFFF); q.push_back(33'h0_0000_0003);
    push_words(q);
    wait_ticks(2 * FRAME + 10);
    rx_frame(33'h1_FFFF_FFFF, 1'b0, "neg1");
    rx_frame(33'h0_0000_0003, 1'b1, "three");
    check_idle("b2b_end");

    // 5: push on full FIFO coinciding with the STOP-end pop
    rd_idx = cyc;
    q.delete();
    for (int i = 1; i <= 5; i++) q.push_back(DW'(32'h100 + i));
    push_words(q);
    wait_ticks(FRAME - 4);
    bus.ALU_Out  = DW'(32'h106);
    bus.ALU_Flag = 1'b1;
    tick();
    bus.ALU_Flag = 1'b0;
    check("fullpop_ovf", 64'(bus.Overflow), 64'(0));
    check("fullpop_nonempty", 64'(bus.Fifo_Empty), 64'(0));
    wait_ticks(5 * FRAME + 10);
    for (int i = 1; i <= 6; i++) rx_frame(DW'(32'h100 + i), i > 1, $sformatf("fullpop%0d", i));
    check("fullpop_ovf_end", 64'(bus.Overflow), 64'(0));
    check_idle("fullpop_end");

    // 4: six consecutive flags into DEPTH=4 -> 1..5 kept, 6 dropped
    rd_idx = cyc;
    q.delete();
    for (int i = 1; i <= 6; i++) q.push_back(DW'(i));
    push_words(q);
    model_ovf = 1'b1;
    check("burst6_ovf", 64'(bus.Overflow), 64'(model_ovf));
    wait_ticks(5 * FRAME + 10);
    for (int i = 1; i <= 5; i++) rx_frame(DW'(i), i > 1, $sformatf("burst6_%0d", i));
    check("burst6_no_sixth", 64'(busy_log[rd_idx]), 64'(0));
    check("burst6_ovf_sticky", 64'(bus.Overflow), 64'(1));

    // Randomized bursts from idle: the first word pops on the 2nd edge
    for (int r = 0; r < 4; r++) begin
      rd_idx = cyc;
      k = $urandom_range(1, 7);
      q.delete(); acc.delete();
      for (int i = 0; i < k; i++) begin
        q.push_back({1'($urandom_range(0, 1)), 32'($urandom)});
        if (i < DEPTH + 1) acc.push_back(q[i]);
      end
      if (k > DEPTH + 1) model_ovf = 1'b1;
      push_words(q);
      wait_ticks(acc.size() * FRAME + 10);
      foreach (acc[i]) rx_frame(acc[i], i > 0, $sformatf("rnd%0d_%0d", r, i));
      check($sformatf("rnd%0d_ovf", r), 64'(bus.Overflow), 64'(model_ovf));
      check_idle($sformatf("rnd%0d_end", r));
    end

    // 6: reset in the middle of the data bits
    q.delete(); q.push_back(33'h0_AAAA_5555); q.push_back(33'h1_0F0F_F0F0);
    push_words(q);
    wait_ticks(6 * CPB + 1);
    check("mid_busy_before", 64'(bus.Busy), 64'(1));
    rst = 1'b0;
    #1;
    check_idle("mid_rst");
    check("mid_rst_ovf", 64'(bus.Overflow), 64'(0));
    wait_ticks(3);
    rst = 1'b1;
    rd_idx = cyc;
    wait_ticks(2 * FRAME);
    line_err = 0;
    for (int i = rd_idx; i < cyc; i++) if (line_log[i] !== 1'b1) line_err++;
    check("mid_rst_no_residual", 64'(line_err), 64'(0));
    check_idle("mid_rst_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_uart_tx.md
Name: alu_result_uart_tx

Overview:
- Reader side of the ALU result interface. Samples the registered result/flag pair that the ALU execution units drive every cycle.
- Buffers the results in a small FIFO and transmits each one off-chip as a UART-style serial frame.
- Sits after the ALU output mux and is the only consumer of the ALU result bus.

Parameters:
- WIDTH, 16: ALU operand width. The result word is DW = 2*WIDTH+1 bits (33 by default).
- DEPTH, 4: FIFO entries. Power of two, >= 2.
- CLKS_PER_BIT, 8: clock cycles per serial bit. Must be >= 2.
- PAR_EN, 1: 1 inserts a parity bit after the data bits.
- PAR_ODD, 0: 0 selects even parity, 1 selects odd parity.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous active-low reset.
- ALU_Out, input, 2*WIDTH+1: signed ALU result word.
- ALU_Flag, input, 1: result-valid. Each cycle it is sampled high is one new result.
- TX_OUT, output, 1: serial line. Idles high.
- Busy, output, 1: high while a frame is on the line.
- Fifo_Empty, output, 1: FIFO holds no entries.
- Overflow, output, 1: sticky. Set when a result is dropped.

Behaviour:
- Reset (rst low, asynchronous):
  - TX_OUT=1, Busy=0, Fifo_Empty=1, Overflow=0.
  - FIFO pointers and count = 0; FSM = IDLE; bit and baud counters = 0.
  - Reset mid-frame aborts the frame immediately: line returns high and no partial state survives.
- Capture:
  - At every rising edge with ALU_Flag=1 and FIFO not full, ALU_Out is written to the FIFO.
  - If the FIFO is full and no pop happens in the same cycle, the word is dropped and Overflow is set to 1. Overflow is cleared only by reset.
  - Push and pop in the same cycle on a full FIFO: both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle on an empty FIFO: not possible, because pop requires a non-empty FIFO.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TX_OUT=1, Busy=0. If the FIFO is non-empty at an edge, pop the head into the shift register, clear the baud counter, go to START.
  - START: TX_OUT=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: TX_OUT = shift register bit, LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit DW-1, go to PARITY if PAR_EN=1, otherwise to STOP.
  - PARITY: TX_OUT = XOR of the DW data bits, XOR PAR_ODD, for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: TX_OUT=1 for CLKS_PER_BIT cycles. At its final cycle, if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Outputs:
  - TX_OUT and Busy are registered. Busy=1 in START, DATA, PARITY and STOP.
- Latency:
  - A flag sampled at edge N into an empty FIFO with the FSM in IDLE gives an entry visible after edge N.
  - Pop happens at edge N+1; TX_OUT falls after edge N+1.
- Frame length: (DW + 2 + PAR_EN) * CLKS_PER_BIT cycles, i.e. 36*CLKS_PER_BIT with default parameters.
- Data integrity: the data word transmitted is exactly the 33-bit ALU_Out captured, sign bit included, with no truncation. The baud counter counts 0..CLKS_PER_BIT-1 and wraps.
- FIFO pointers: log2(DEPTH) bits, wrap modulo DEPTH. Count is 0..DEPTH.
- ALU_Flag is ignored while rst is low.

Decomposition:
- Shared header (`define file):
  - FSM state encodings: IDLE=3'd0, START=1, DATA=2, PARITY=3, STOP=4.
  - Idle/stop line level (1) and start level (0).
- Sub-module alu_result_fifo: synchronous FIFO, DW x DEPTH.
  - Inputs: push, pop. Outputs: rd_data, full, empty.
  - Same clk/rst.
- Top level contains the FSM, baud counter, bit counter, parity and overflow logic.

Test Plan (all scenarios with CLKS_PER_BIT=4, PAR_EN=1, PAR_ODD=0):
1. Reset hold, then release with ALU_Flag=0 for 20 cycles -> TX_OUT=1, Busy=0, Fifo_Empty=1, Overflow=0 throughout.
2. Single push of ALU_Out=33'h0_0000_0001 -> frame over 144 cycles: start 0, then 1 followed by 32 zeros, parity 1, stop 1. Busy low after the frame.
3. Push 33'h1_FFFF_FFFF (-1) -> 33 data ones, parity 1. Then push 33'h0_0000_0003 -> parity 0. Frames back-to-back with no idle cycle between stops and start.
4. Hold ALU_Flag=1 for 6 cycles with ALU_Out = 1..6, DEPTH=4:
   - Pop of 1 occurs at the 2nd edge, so 1..5 are accepted and 6 is dropped; Overflow=1.
   - Line carries 1,2,3,4,5 in order; Overflow stays 1 until reset.
5. Push one word while the FIFO is full and the FSM pops at the end of STOP in the same edge -> word accepted, count stays 4, Overflow stays 0.
6. Assert rst mid-DATA of a frame -> TX_OUT=1, Busy=0 and FIFO empty immediately. After release, no residual frame is transmitted.
